// File: rtl/gray_chk_pkg.sv
// Shared types and helpers for the Gray-sequence checker.
//   state_e   : checker FSM states
//   gray2bin  : Gray -> binary on an FN_W-bit word
//   bin2gray  : binary -> Gray on an FN_W-bit word
//   popcount  : number of set bits in an FN_W-bit word
// The helpers work on a fixed FN_W-bit word. A narrower WIDTH-bit value that
// is zero-extended gives the same low WIDTH bits, so any WIDTH <= FN_W works.
package gray_chk_pkg;

  localparam int unsigned GRAY_W_DEF     = 5;
  localparam int unsigned ERR_W_DEF      = 8;
  localparam int unsigned LOCK_COUNT_DEF = 4;
  localparam int unsigned FN_W           = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_e;

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = '0;
    b[FN_W-1] = g[FN_W-1];
    for (int unsigned i = FN_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [FN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < FN_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational WIDTH-bit Gray-to-binary decoder.
//   gray_i : Gray-coded input word
//   bin_o  : binary equivalent
// Each binary bit is the XOR of all Gray bits at or above its position
// (the prefix chain written as a reduction to avoid a self-referencing loop).
module gray2bin_dec
  import gray_chk_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEF
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/gray_seq_checker.sv
// Monitors a Gray counter output and checks each sample against the value
// implied by the previous sample and the counter enable.
//   clk           : system clock, rising edge
//   reset_L       : synchronous active-low reset
//   enable        : enable driven to the Gray counter
//   gray_in       : Gray counter output
//   bin_out       : registered binary decode of gray_in (1-cycle latency)
//   step_err      : pulse, sample differs from expected value
//   multi_bit_err : pulse, more than one bit changed since the last sample
//   wrap          : pulse, legal step from all-ones to zero
//   locked        : LOCK_COUNT consecutive good checks since last error/reset
//   err_count     : saturating count of step_err events
module gray_seq_checker
  import gray_chk_pkg::*;
#(
  parameter int unsigned WIDTH      = GRAY_W_DEF,
  parameter int unsigned ERR_W      = ERR_W_DEF,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_err,
  output logic             multi_bit_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  // Wide enough for LOCK_COUNT up to 15.
  localparam int unsigned CNT_W = 4;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_gray_q;
  logic             prev_en_q;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0] bin_q;
  logic             step_err_q, step_err_d;
  logic             multi_q, multi_d;
  logic             wrap_q, wrap_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] bin_in;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] prev_bin_inc;
  logic [WIDTH-1:0] exp_gray;
  logic             chk_bad;
  logic             chk_multi;

  gray2bin_dec #(.WIDTH(WIDTH)) u_dec_in (
    .gray_i (gray_in),
    .bin_o  (bin_in)
  );

  gray2bin_dec #(.WIDTH(WIDTH)) u_dec_prev (
    .gray_i (prev_gray_q),
    .bin_o  (prev_bin)
  );

  // The counter advances on the edge where it saw enable=1, so the change is
  // visible one sample later: expectation uses the enable captured last time.
  assign prev_bin_inc = prev_bin + WIDTH'(1);
  assign exp_gray     = prev_en_q ? WIDTH'(bin2gray(FN_W'(prev_bin_inc))) : prev_gray_q;
  assign chk_bad      = (gray_in != exp_gray);
  assign chk_multi    = (popcount(FN_W'(gray_in ^ prev_gray_q)) > 1);

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    step_err_d = 1'b0;
    multi_d    = 1'b0;
    wrap_d     = 1'b0;
    locked_d   = locked_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        state_d = ACQUIRE;
      end
      ACQUIRE, LOCKED: begin
        step_err_d = chk_bad;
        multi_d    = chk_multi;
        wrap_d     = prev_en_q & ~chk_bad & (prev_bin == '1) & (gray_in == '0);
        if (chk_bad) begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
          locked_d   = 1'b0;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end else if (state_q == ACQUIRE) begin
          good_cnt_d = good_cnt_q + CNT_W'(1);
          if (good_cnt_d == CNT_W'(LOCK_COUNT)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      prev_gray_q <= '0;
      prev_en_q   <= 1'b0;
      good_cnt_q  <= '0;
      bin_q       <= '0;
      step_err_q  <= 1'b0;
      multi_q     <= 1'b0;
      wrap_q      <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_gray_q <= gray_in;
      prev_en_q   <= enable;
      good_cnt_q  <= good_cnt_d;
      bin_q       <= bin_in;
      step_err_q  <= step_err_d;
      multi_q     <= multi_d;
      wrap_q      <= wrap_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out       = bin_q;
  assign step_err      = step_err_q;
  assign multi_bit_err = multi_q;
  assign wrap          = wrap_q;
  assign locked        = locked_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
module tb_gray_seq_checker;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enable;
  logic [4:0] gray_in;
  logic [4:0] bin_out;
  logic       step_err;
  logic       multi_bit_err;
  logic       wrap;
  logic       locked;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int m_prev_g, m_prev_en, m_good, m_err;
  int m_started, m_locked;
  int e_bin, e_step, e_multi, e_wrap;
  // Stimulus-side counter (binary value the Gray counter would present next).
  int cnt;
  int wraps_seen;

  gray_seq_checker #(
    .WIDTH      (5),
    .ERR_W      (8),
    .LOCK_COUNT (4)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enable        (enable),
    .gray_in       (gray_in),
    .bin_out       (bin_out),
    .step_err      (step_err),
    .multi_bit_err (multi_bit_err),
    .wrap          (wrap),
    .locked        (locked),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  function automatic int g2b(input int g);
    int b;
    b = g;
    for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

  function automatic int b2g(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int m_exp();
    if (m_prev_en != 0) return b2g((g2b(m_prev_g) + 1) % 32);
    return m_prev_g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [4:0] g);
    int xg;
    int ex;
    reset_L = rst;
    enable  = en;
    gray_in = g;
    @(posedge clk);
    #1;
    xg = int'(g);
    if (!rst) begin
      m_prev_g = 0; m_prev_en = 0; m_good = 0; m_err = 0;
      m_started = 0; m_locked = 0;
      e_bin = 0; e_step = 0; e_multi = 0; e_wrap = 0;
      cnt = 0;
    end else begin
      e_bin = g2b(xg);
      e_step = 0; e_multi = 0; e_wrap = 0;
      if (m_started != 0) begin
        ex = m_exp();
        e_step  = (xg != ex) ? 1 : 0;
        e_multi = ($countones(xg ^ m_prev_g) > 1) ? 1 : 0;
        e_wrap  = (m_prev_en != 0 && e_step == 0 && g2b(m_prev_g) == 31 && xg == 0) ? 1 : 0;
        if (e_step != 0) begin
          if (m_err < 255) m_err++;
          m_good = 0;
          m_locked = 0;
        end else if (m_locked == 0) begin
          m_good++;
          if (m_good >= 4) m_locked = 1;
        end
      end
      m_started = 1;
      m_prev_g  = xg;
      m_prev_en = en ? 1 : 0;
      cnt = en ? (g2b(xg) + 1) % 32 : g2b(xg);
    end
    chk("bin_out",       32'(bin_out),       32'(e_bin));
    chk("step_err",      32'(step_err),      32'(e_step));
    chk("multi_bit_err", 32'(multi_bit_err), 32'(e_multi));
    chk("wrap",          32'(wrap),          32'(e_wrap));
    chk("locked",        32'(locked),        32'(m_locked));
    chk("err_count",     32'(err_count),     32'(m_err));
    if (wrap === 1'b1) wraps_seen++;
  endtask

  task automatic legal(input int n, input bit rand_en);
    logic en;
    for (int i = 0; i < n; i++) begin
      en = rand_en ? 1'($urandom % 2) : 1'b1;
      step(1'b1, en, 5'(b2g(cnt)));
    end
  endtask

  task automatic legal_until(input int target);
    for (int i = 0; i < 64 && cnt != target; i++) legal(1, 1'b0);
  endtask

  initial begin
    int ex;
    logic en;
    reset_L = 1'b0; enable = 1'b0; gray_in = '0;
    cnt = 0; wraps_seen = 0;

    // Reset for two cycles, then hold with enable=0.
    step(1'b0, 1'b0, 5'b00000);
    step(1'b0, 1'b0, 5'b00000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5'b00000);
    chk("not_locked_after_4", 32'(locked), 32'd0);
    step(1'b1, 1'b0, 5'b00000);
    chk("locked_5th_edge", 32'(locked), 32'd1);
    chk("err_after_hold", 32'(err_count), 32'd0);

    // Legal counting through a wrap.
    wraps_seen = 0;
    legal(40, 1'b0);
    chk("wrap_once", 32'(wraps_seen), 32'd1);

    // Single-bit wrong value while locked.
    legal_until(2);
    step(1'b1, 1'b1, 5'b00011);
    step(1'b1, 1'b1, 5'b00001);
    chk("inj1_step", 32'(step_err), 32'd1);
    chk("inj1_multi", 32'(multi_bit_err), 32'd0);
    chk("inj1_unlock", 32'(locked), 32'd0);
    chk("inj1_errcnt", 32'(err_count), 32'd1);
    legal(3, 1'b0);
    chk("relock_not_yet", 32'(locked), 32'd0);
    legal(1, 1'b0);
    chk("relock_4", 32'(locked), 32'd1);

    // Multi-bit jump 00001 -> 01110.
    legal_until(1);
    step(1'b1, 1'b1, 5'b00001);
    step(1'b1, 1'b1, 5'b01110);
    chk("inj2_step", 32'(step_err), 32'd1);
    chk("inj2_multi", 32'(multi_bit_err), 32'd1);
    chk("inj2_errcnt", 32'(err_count), 32'd2);

    // Error every cycle to saturate the counter.
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom % 2);
      ex = m_exp();
      step(1'b1, en, 5'(ex ^ int'($urandom_range(1, 31))));
    end
    chk("err_saturated", 32'(err_count), 32'd255);
    chk("sat_step_pulse", 32'(step_err), 32'd1);

    // Recover, run to 17, reset mid-sequence, resume from 0.
    legal(20, 1'b1);
    legal_until(17);
    step(1'b0, 1'b1, 5'(b2g(17)));
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    legal(5, 1'b0);
    chk("post_rst_nostep", 32'(step_err), 32'd0);
    chk("post_rst_locked", 32'(locked), 32'd1);

    // Random enable patterns, then enable toggling every cycle.
    legal(60, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'(i % 2), 5'(b2g(cnt)));
    chk("toggle_locked", 32'(locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
